// File: rtl/irq_conditioner_pkg.sv
// Shared constants and types for the interrupt conditioner: line count, register offsets,
// reset values and the bus response state.
package irq_conditioner_pkg;

    localparam int unsigned NumLines = 4;
    localparam int unsigned DbCntW   = 20;

    localparam logic [3:0] OffPending = 4'h0;
    localparam logic [3:0] OffEnable  = 4'h4;
    localparam logic [3:0] OffCount   = 4'h8;
    localparam logic [3:0] OffLevel   = 4'hC;

    localparam logic [NumLines-1:0] EnableRst = 4'hF;

    typedef enum logic {StIdle, StResp} bus_state_e;

    function automatic logic [7:0] popcount(input logic [NumLines-1:0] v);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < NumLines; i++) begin
            cnt = cnt + 8'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/irq_debounce.sv
// One interrupt line: 2-flop synchronizer followed by a saturating-window debounce counter
// that updates the stable level only after DEBOUNCE_CYCLES consistent samples.
module irq_debounce
    import irq_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic stable_o
);

    localparam logic [DbCntW-1:0] CntMax = DbCntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]        sync_q;
    logic [DbCntW-1:0] cnt_q, cnt_d;
    logic              stable_q, stable_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/irq_conditioner.sv
// Four debounced interrupt lines with rising-edge pending latches, enable mask, edge counter
// and a 4-register native-bus window answered one cycle after the request.
module irq_conditioner
    import irq_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0010
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [3:0]  irq_raw_i,
    input  logic        bus_valid_i,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    input  logic [3:0]  bus_wstrb_i,
    output logic        bus_ready_o,
    output logic [31:0] bus_rdata_o,
    output logic [3:0]  irq_out_o,
    output logic [7:0]  irq_counter_o
);

    logic [NumLines-1:0] stable;
    logic [NumLines-1:0] stable_prev_q;
    logic [NumLines-1:0] rise;
    logic [NumLines-1:0] pending_q, pending_d;
    logic [NumLines-1:0] enable_q, enable_d;
    logic [7:0]          count_q, count_d;
    logic [31:0]         rdata_q, rdata_d;
    bus_state_e          state_q, state_d;

    logic [31:0] offset;
    logic        accept, is_wr, wr_en;
    logic [31:0] rd_val;
    logic        unused_bits;

    for (genvar i = 0; i < NumLines; i++) begin : g_line
        irq_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .raw_i   (irq_raw_i[i]),
            .stable_o(stable[i])
        );
    end

    assign rise = stable & ~stable_prev_q;

    // Unsigned subtraction also rejects addresses below the base.
    assign offset = bus_addr_i - BASE_ADDR;
    assign accept = bus_valid_i && (offset < 32'd16) && (state_q == StIdle);
    assign is_wr  = accept && (bus_wstrb_i != 4'b0000);
    assign wr_en  = is_wr && bus_wstrb_i[0];

    always_comb begin
        rd_val = '0;
        unique case (offset[3:2])
            OffPending[3:2]: rd_val[NumLines-1:0] = pending_q;
            OffEnable[3:2]:  rd_val[NumLines-1:0] = enable_q;
            OffCount[3:2]:   rd_val[7:0]          = count_q;
            OffLevel[3:2]:   rd_val[NumLines-1:0] = stable;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        enable_d  = enable_q;
        count_d   = count_q + popcount(rise);
        rdata_d   = '0;
        state_d   = StIdle;

        if (accept) begin
            state_d = StResp;
            if (!is_wr) begin
                rdata_d = rd_val;
            end
        end

        if (wr_en) begin
            unique case (offset[3:2])
                OffPending[3:2]: pending_d = pending_q & ~bus_wdata_i[NumLines-1:0];
                OffEnable[3:2]:  enable_d  = bus_wdata_i[NumLines-1:0];
                OffCount[3:2]:   count_d   = popcount(rise);
                OffLevel[3:2]:   ;
            endcase
        end

        // New edges override a same-cycle W1C.
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stable_prev_q <= '0;
            pending_q     <= '0;
            enable_q      <= EnableRst;
            count_q       <= '0;
            rdata_q       <= '0;
            state_q       <= StIdle;
        end else begin
            stable_prev_q <= stable;
            pending_q     <= pending_d;
            enable_q      <= enable_d;
            count_q       <= count_d;
            rdata_q       <= rdata_d;
            state_q       <= state_d;
        end
    end

    assign bus_ready_o   = (state_q == StResp);
    assign bus_rdata_o   = rdata_q;
    assign irq_out_o     = pending_q & enable_q;
    assign irq_counter_o = count_q;

    assign unused_bits = ^{bus_wdata_i[31:8], offset[1:0]};

endmodule

// File: tb/tb_irq_conditioner.sv
// Scoreboard bench for irq_conditioner with DEBOUNCE_CYCLES=4: bus responses are checked by a
// monitor against expectations queued at issue time; side outputs are checked inline.
module tb_irq_conditioner;

    localparam logic [31:0] Base = 32'h1000_0010;
    localparam logic [31:0] OPend = 32'h0;
    localparam logic [31:0] OEn   = 32'h4;
    localparam logic [31:0] OCnt  = 32'h8;
    localparam logic [31:0] OLvl  = 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_raw;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [3:0]  irq_out;
    logic [7:0]  irq_counter;

    logic [31:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    irq_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .BASE_ADDR      (Base)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .irq_raw_i    (irq_raw),
        .bus_valid_i  (bus_valid),
        .bus_addr_i   (bus_addr),
        .bus_wdata_i  (bus_wdata),
        .bus_wstrb_i  (bus_wstrb),
        .bus_ready_o  (bus_ready),
        .bus_rdata_o  (bus_rdata),
        .irq_out_o    (irq_out),
        .irq_counter_o(irq_counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every bus_ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ready_outstanding", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("rdata", bus_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                       input string name, input logic [31:0] exp_rdata, input logic exp_ready);
        bus_valid = 1'b1;
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_wstrb = strb;
        if (exp_ready) exp_q.push_back(exp_rdata);
        step(1);
        bus_valid = 1'b0;
        bus_wstrb = 4'h0;
        chk({name, "_ready"}, 32'(bus_ready), 32'(exp_ready));
        step(1);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        bus(Base + off, 32'h0, 4'h0, name, exp, 1'b1);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] strb,
                      input string name);
        bus(Base + off, data, strb, name, 32'h0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        irq_raw   = 4'h0;
        bus_valid = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wstrb = 4'h0;
        step(3);
        reset = 1'b0;

        chk("rst_irq_out", 32'(irq_out), 32'h0);
        chk("rst_counter", 32'(irq_counter), 32'h0);
        chk("rst_ready", 32'(bus_ready), 32'h0);
        rd(OEn, 32'hF, "rst_enable");
        rd(OPend, 32'h0, "rst_pending");
        rd(OCnt, 32'h0, "rst_count");
        rd(OLvl, 32'h0, "rst_level");

        // 3-cycle glitch must be rejected
        irq_raw[0] = 1'b1;
        step(3);
        irq_raw[0] = 1'b0;
        step(10);
        rd(OLvl, 32'h0, "glitch_level");
        rd(OPend, 32'h0, "glitch_pending");
        chk("glitch_counter", 32'(irq_counter), 32'h0);

        // Held edge on line 1: accepted exactly 7 cycles later
        irq_raw[1] = 1'b1;
        step(6);
        chk("edge1_early_irq", 32'(irq_out), 32'h0);
        chk("edge1_early_cnt", 32'(irq_counter), 32'h0);
        step(1);
        chk("edge1_irq_out", 32'(irq_out), 32'h2);
        chk("edge1_counter", 32'(irq_counter), 32'h1);
        rd(OPend, 32'h2, "edge1_pending");
        rd(OLvl, 32'h2, "edge1_level");

        // W1C and strobe gating
        irq_raw[0] = 1'b1;
        step(8);
        rd(OPend, 32'h3, "two_pending");
        chk("two_counter", 32'(irq_counter), 32'h2);
        wr(OPend, 32'h1, 4'hF, "w1c");
        rd(OPend, 32'h2, "w1c_pending");
        chk("w1c_irq_out", 32'(irq_out), 32'h2);
        wr(OPend, 32'h2, 4'b1110, "nostrb");
        rd(OPend, 32'h2, "nostrb_pending");

        // Enable masking keeps pending
        wr(OEn, 32'h0, 4'h1, "en_off");
        chk("masked_irq_out", 32'(irq_out), 32'h0);
        irq_raw[2] = 1'b1;
        step(8);
        chk("masked_irq_out2", 32'(irq_out), 32'h0);
        chk("masked_counter", 32'(irq_counter), 32'h3);
        rd(OPend, 32'h6, "masked_pending");
        wr(OEn, 32'hF, 4'h1, "en_on");
        chk("unmasked_irq_out", 32'(irq_out), 32'h6);

        // Out-of-window accesses are ignored
        bus(Base + 32'h14, 32'h0, 4'hF, "oow_hi", 32'h0, 1'b0);
        bus(Base - 32'h4, 32'h0, 4'hF, "oow_lo", 32'h0, 1'b0);
        chk("oow_irq_out", 32'(irq_out), 32'h6);
        chk("oow_counter", 32'(irq_counter), 32'h3);

        // Valid held two cycles yields a single response
        bus_valid = 1'b1;
        bus_addr  = Base + OLvl;
        bus_wstrb = 4'h0;
        exp_q.push_back(32'h7);
        step(1);
        chk("b2b_first_ready", 32'(bus_ready), 32'h1);
        step(1);
        bus_valid = 1'b0;
        chk("b2b_second_ready", 32'(bus_ready), 32'h0);
        step(1);

        // Drive counter to 254
        irq_raw = 4'h0;
        step(8);
        wr(OCnt, 32'hFFFF_FFFF, 4'hF, "cnt_clr");
        chk("cnt_clr_counter", 32'(irq_counter), 32'h0);
        for (int i = 0; i < 63; i++) begin
            irq_raw = 4'hF;
            step(8);
            irq_raw = 4'h0;
            step(8);
        end
        chk("cnt_252", 32'(irq_counter), 32'd252);
        for (int i = 0; i < 2; i++) begin
            irq_raw = 4'h1;
            step(8);
            irq_raw = 4'h0;
            step(8);
        end
        rd(OCnt, 32'd254, "cnt_254");

        // Four simultaneous edges wrap the counter; edge beats coincident W1C of bit 3
        wr(OPend, 32'h7, 4'h1, "pre_w1c");
        rd(OPend, 32'h8, "pre_w1c_pending");
        irq_raw = 4'hF;
        step(6);
        wr(OPend, 32'h8, 4'h1, "coinc_w1c");
        chk("wrap_counter", 32'(irq_counter), 32'h2);
        rd(OPend, 32'hF, "coinc_pending");

        // Edges coincident with COUNT clear
        irq_raw = 4'h0;
        step(8);
        irq_raw = 4'h3;
        step(6);
        wr(OCnt, 32'h0, 4'h1, "coinc_cnt_clr");
        chk("coinc_clr_counter", 32'(irq_counter), 32'h2);
        rd(OCnt, 32'h2, "coinc_clr_read");

        // Reset in the middle of an access
        chk("pre_rst_irq_out", 32'(irq_out), 32'hF);
        bus_valid = 1'b1;
        bus_addr  = Base + OPend;
        bus_wstrb = 4'h0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_irq_out", 32'(irq_out), 32'h0);
        chk("midrst_counter", 32'(irq_counter), 32'h0);
        chk("midrst_ready", 32'(bus_ready), 32'h0);
        step(2);
        bus_valid = 1'b0;
        chk("midrst_ready2", 32'(bus_ready), 32'h0);
        reset = 1'b0;

        // Lines held high through reset are accepted after 2+DEBOUNCE cycles
        step(6);
        chk("postrst_early_cnt", 32'(irq_counter), 32'h0);
        step(1);
        chk("postrst_counter", 32'(irq_counter), 32'h2);
        chk("postrst_irq_out", 32'(irq_out), 32'h3);
        rd(OPend, 32'h3, "postrst_pending");
        rd(OEn, 32'hF, "postrst_enable");

        step(3);
        chk("outstanding", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
